// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, parity modes, baud divisor table.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // Clocks per sample tick for each baud selection (truncated division).
    // Each branch divides constants only, so no runtime divider is built.
    function automatic int unsigned baud_div(input int unsigned clk_hz,
                                             input int unsigned oversample,
                                             input logic [2:0]  sel);
        case (sel)
            3'd0:    return clk_hz / (oversample * 300);
            3'd1:    return clk_hz / (oversample * 1200);
            3'd2:    return clk_hz / (oversample * 4800);
            3'd3:    return clk_hz / (oversample * 9600);
            3'd4:    return clk_hz / (oversample * 19200);
            3'd5:    return clk_hz / (oversample * 38400);
            3'd6:    return clk_hz / (oversample * 57600);
            default: return clk_hz / (oversample * 115200);
        endcase
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; a level counter separates full from empty.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 11,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic [AW:0]      count;
    logic             rd_ok, wr_ok;

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign rd_ok = pop && !empty;
    // A push into a full FIFO is accepted when the head leaves in the same cycle.
    assign wr_ok = push && (!full || rd_ok);
    assign dout  = mem[rptr];
    assign level = count;

    // Storage write; contents need no reset because the head is qualified by empty.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wptr] <= din;
        end
    end

    // Pointer and level bookkeeping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_ok) wptr <= wptr + AW'(1);
            if (rd_ok) rptr <= rptr + AW'(1);
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo_param.sv
// Oversampling UART receiver with majority vote, parity, break/overrun detection and output FIFO.
module uart_rx_fifo_param
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [2:0]                    baud_select,
    input  logic [1:0]                    parity_mode,
    input  logic                          rx_en,
    input  logic                          rxd,
    input  logic                          rx_pop,
    input  logic                          ovr_clr,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_valid,
    output logic                          rx_perror,
    output logic                          rx_ferror,
    output logic                          rx_break,
    output logic                          rx_overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned DIV_W = $clog2(baud_div(CLK_HZ, OVERSAMPLE, 3'd0) + 1);
    localparam int unsigned SC_W  = $clog2(OVERSAMPLE);
    localparam int unsigned FW    = DATA_BITS + 3;
    localparam logic [SC_W-1:0] S_DECIDE = SC_W'(OVERSAMPLE/2 + 1);
    localparam logic [SC_W-1:0] S_LAST   = SC_W'(OVERSAMPLE - 1);

    logic                 sync1, rxd_s, rxd_d;
    rx_state_t            state, state_n;
    logic [DIV_W-1:0]     div_q, div_cnt;
    logic [SC_W-1:0]      samp_cnt;
    logic [1:0]           vote_q;
    logic [1:0]           pmode_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [3:0]           bit_cnt;
    logic                 par_q, perror_q, ferror_q;

    logic                 tick, decide, bit_val, start_det, par_en, exp_par;
    logic                 push, drop, frame_start, ferr_final, brk;
    logic [FW-1:0]        fifo_din, fifo_dout;
    logic                 fifo_empty, fifo_full;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b1;
            rxd_s <= 1'b1;
            rxd_d <= 1'b1;
        end else begin
            sync1 <= rxd;
            rxd_s <= sync1;
            rxd_d <= rxd_s;
        end
    end

    assign tick      = (state != IDLE) && (div_cnt == div_q - DIV_W'(1));
    assign decide    = tick && (samp_cnt == S_DECIDE);
    // vote_q holds the two previous samples; the current sample completes the vote.
    assign bit_val   = (vote_q[1] & vote_q[0]) | (vote_q[1] & rxd_s) | (vote_q[0] & rxd_s);
    assign start_det = rx_en && rxd_d && !rxd_s;
    assign par_en    = (pmode_q == PAR_EVEN) || (pmode_q == PAR_ODD);
    assign exp_par   = (^shift_q) ^ (pmode_q == PAR_ODD);

    // FSM register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    // Next-state and push decision; bits are resolved at mid-bit, not at bit boundaries.
    always_comb begin
        state_n = state;
        push    = 1'b0;
        case (state)
            IDLE:   if (start_det) state_n = START;
            START:  if (decide) state_n = bit_val ? IDLE : DATA;
            DATA:   if (decide && bit_cnt == 4'(DATA_BITS-1)) state_n = par_en ? PARITY : STOP;
            PARITY: if (decide) state_n = STOP;
            STOP: begin
                if (decide && bit_cnt == 4'(STOP_BITS-1)) begin
                    state_n = IDLE;
                    push    = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        if (!rx_en && state != IDLE) begin
            state_n = IDLE;
            push    = 1'b0;
        end
    end

    assign frame_start = (state == IDLE) && (state_n == START);

    // Baud/sample timing, frame settings latch, shift register and error accumulation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q    <= '0;
            div_cnt  <= '0;
            samp_cnt <= '0;
            vote_q   <= '0;
            pmode_q  <= PAR_NONE;
            shift_q  <= '0;
            bit_cnt  <= '0;
            par_q    <= 1'b0;
            perror_q <= 1'b0;
            ferror_q <= 1'b0;
        end else if (frame_start) begin
            div_q    <= DIV_W'(baud_div(CLK_HZ, OVERSAMPLE, baud_select));
            div_cnt  <= '0;
            samp_cnt <= '0;
            pmode_q  <= parity_mode;
            bit_cnt  <= '0;
            par_q    <= 1'b0;
            perror_q <= 1'b0;
            ferror_q <= 1'b0;
        end else if (state != IDLE) begin
            if (tick) begin
                div_cnt  <= '0;
                samp_cnt <= (samp_cnt == S_LAST) ? '0 : samp_cnt + SC_W'(1);
                vote_q   <= {vote_q[0], rxd_s};
            end else begin
                div_cnt  <= div_cnt + DIV_W'(1);
            end
            if (decide) begin
                case (state)
                    DATA: begin
                        shift_q <= {bit_val, shift_q[DATA_BITS-1:1]};
                        bit_cnt <= (bit_cnt == 4'(DATA_BITS-1)) ? '0 : bit_cnt + 4'(1);
                    end
                    PARITY: begin
                        par_q    <= bit_val;
                        perror_q <= (bit_val != exp_par);
                    end
                    STOP: begin
                        ferror_q <= ferror_q | ~bit_val;
                        bit_cnt  <= bit_cnt + 4'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    // Word pushed at the last stop mid-point, folding in that final stop vote.
    always_comb begin
        ferr_final = ferror_q | ~bit_val;
        brk        = (shift_q == '0) && (!par_en || !par_q) && ferr_final;
        fifo_din   = {brk, ferr_final, perror_q, shift_q};
    end

    assign drop = push && fifo_full && !rx_pop;

    uart_sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (rx_pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .level (fifo_level)
    );

    // Sticky overrun; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       rx_overrun <= 1'b0;
        else if (drop)    rx_overrun <= 1'b1;
        else if (ovr_clr) rx_overrun <= 1'b0;
    end

    assign rx_valid = !fifo_empty;
    assign {rx_break, rx_ferror, rx_perror, rx_data} = fifo_empty ? '0 : fifo_dout;

endmodule

// File: tb/tb_uart_rx_fifo_param.sv
// Self-checking bench for uart_rx_fifo_param at 115200 baud, 8 data bits, 1 stop bit.
module tb_uart_rx_fifo_param;

    localparam int unsigned DIV = 27;
    localparam int unsigned BIT = DIV * 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] baud_select;
    logic [1:0] parity_mode;
    logic       rx_en, rxd, rx_pop, ovr_clr;
    logic [7:0] rx_data;
    logic       rx_valid, rx_perror, rx_ferror, rx_break, rx_overrun;
    logic [3:0] fifo_level;
    logic [10:0] head;

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;
    int unsigned rise_cyc = 0;
    logic        v_prev = 1'b0;
    logic [10:0] exp_q[$];

    uart_rx_fifo_param #(
        .CLK_HZ     (50_000_000),
        .DATA_BITS  (8),
        .STOP_BITS  (1),
        .OVERSAMPLE (16),
        .FIFO_DEPTH (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .baud_select (baud_select),
        .parity_mode (parity_mode),
        .rx_en       (rx_en),
        .rxd         (rxd),
        .rx_pop      (rx_pop),
        .ovr_clr     (ovr_clr),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_perror   (rx_perror),
        .rx_ferror   (rx_ferror),
        .rx_break    (rx_break),
        .rx_overrun  (rx_overrun),
        .fifo_level  (fifo_level)
    );

    assign head = {rx_break, rx_ferror, rx_perror, rx_data};

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Cycle at which rx_valid last rose, observed on the falling edge.
    always @(negedge clk) begin
        if (rx_valid && !v_prev) rise_cyc <= cyc;
        v_prev <= rx_valid;
    end

    function automatic logic parity_on(input logic [1:0] pm);
        return (pm == 2'b01) || (pm == 2'b10);
    endfunction

    // Parity bit a correct transmitter would send.
    function automatic logic good_parity(input logic [7:0] d, input logic [1:0] pm);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += d[i];
        return (pm == 2'b10) ? ((ones % 2) == 0) : ((ones % 2) == 1);
    endfunction

    // Expected FIFO entry {break, ferror, perror, data} for a frame as sent on the line.
    function automatic logic [10:0] model_word(input logic [7:0] d, input logic [1:0] pm,
                                               input logic pb, input logic sb);
        logic pe, fe, bk;
        pe = parity_on(pm) && (pb != good_parity(d, pm));
        fe = (sb == 1'b0);
        bk = (d == 8'h00) && (!parity_on(pm) || pb == 1'b0) && fe;
        return {bk, fe, pe, d};
    endfunction

    // Drives one frame starting now (called at a falling edge); bc = clocks per bit.
    task automatic send_frame(input logic [7:0] d, input logic [1:0] pm, input logic pb,
                              input logic sb, input int unsigned bc);
        parity_mode = pm;
        rxd = 1'b0;
        repeat (bc) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            repeat (bc) @(negedge clk);
        end
        if (parity_on(pm)) begin
            rxd = pb;
            repeat (bc) @(negedge clk);
        end
        rxd = sb;
        repeat (bc) @(negedge clk);
        rxd = 1'b1;
        if (!sb) repeat (bc / 4) @(negedge clk);
    endtask

    task automatic pop_one();
        rx_pop = 1'b1;
        @(negedge clk);
        rx_pop = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", rx_valid); end
        checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
        checks++; if (rx_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", rx_overrun); end
        checks++; if (head !== 11'h000) begin errors++; $display("FAIL reset_head: got %h expected 000", head); end
        reset = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_basic();
        int unsigned start;
        int lat;
        logic [10:0] exp;
        start = cyc;
        send_frame(8'hA5, 2'b01, good_parity(8'hA5, 2'b01), 1'b1, BIT);
        exp = model_word(8'hA5, 2'b01, good_parity(8'hA5, 2'b01), 1'b1);
        lat = int'(rise_cyc) - int'(start);
        checks++;
        if (lat < int'(10*BIT + 7*DIV) || lat > int'(10*BIT + 11*DIV + 8)) begin
            errors++; $display("FAIL basic_latency: got %0d clk expected %0d..%0d", lat, 10*BIT + 7*DIV, 10*BIT + 11*DIV + 8);
        end
        checks++; if (head !== exp) begin errors++; $display("FAIL basic_word: got %h expected %h", head, exp); end
        checks++; if (fifo_level !== 4'd1) begin errors++; $display("FAIL basic_level: got %0d expected 1", fifo_level); end
        pop_one();
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL basic_pop_valid: got %b expected 0", rx_valid); end
    endtask

    task automatic test_parity_error();
        logic pb;
        logic [10:0] exp;
        pb = ~good_parity(8'hA1, 2'b10);
        send_frame(8'hA1, 2'b10, pb, 1'b1, BIT);
        exp = model_word(8'hA1, 2'b10, pb, 1'b1);
        checks++; if (head !== exp) begin errors++; $display("FAIL parity_word: got %h expected %h", head, exp); end
        checks++; if (rx_perror !== 1'b1) begin errors++; $display("FAIL parity_flag: got %b expected 1", rx_perror); end
        pop_one();
    endtask

    task automatic test_framing_break();
        logic [10:0] exp;
        send_frame(8'h3C, 2'b00, 1'b0, 1'b0, BIT);
        exp = model_word(8'h3C, 2'b00, 1'b0, 1'b0);
        checks++; if (head !== exp) begin errors++; $display("FAIL ferror_word: got %h expected %h", head, exp); end
        checks++; if (rx_break !== 1'b0) begin errors++; $display("FAIL ferror_nobreak: got %b expected 0", rx_break); end
        pop_one();
        send_frame(8'h00, 2'b01, 1'b0, 1'b0, BIT);
        exp = model_word(8'h00, 2'b01, 1'b0, 1'b0);
        checks++; if (head !== exp) begin errors++; $display("FAIL break_word: got %h expected %h", head, exp); end
        checks++; if (rx_break !== 1'b1 || rx_ferror !== 1'b1) begin
            errors++; $display("FAIL break_flags: got brk=%b fe=%b expected brk=1 fe=1", rx_break, rx_ferror);
        end
        pop_one();
    endtask

    task automatic test_false_start();
        rxd = 1'b0;
        repeat (4 * DIV) @(negedge clk);
        rxd = 1'b1;
        repeat (BIT) @(negedge clk);
        checks++; if (rx_valid !== 1'b0 || fifo_level !== 4'd0) begin
            errors++; $display("FAIL false_start: got valid=%b level=%0d expected valid=0 level=0", rx_valid, fifo_level);
        end
    endtask

    task automatic test_abort();
        rxd = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rxd = i[0];
            repeat (BIT) @(negedge clk);
        end
        rxd = 1'b1;
        repeat (BIT / 2) @(negedge clk);
        rx_en = 1'b0;
        repeat (BIT) @(negedge clk);
        checks++; if (rx_valid !== 1'b0 || fifo_level !== 4'd0) begin
            errors++; $display("FAIL abort_no_push: got valid=%b level=%0d expected valid=0 level=0", rx_valid, fifo_level);
        end
        rx_en = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_random();
        logic [7:0]  d;
        logic [1:0]  pm;
        logic        pb, sb;
        logic [10:0] exp;
        for (int n = 0; n < 2; n++) begin
            d  = 8'($urandom_range(0, 255));
            pm = 2'($urandom_range(0, 3));
            pb = good_parity(d, pm) ^ 1'($urandom_range(0, 1));
            sb = 1'($urandom_range(0, 1));
            send_frame(d, pm, pb, sb, BIT);
            exp = model_word(d, pm, pb, sb);
            checks++; if (head !== exp) begin errors++; $display("FAIL random_word[%0d]: got %h expected %h", n, head, exp); end
            checks++; if (fifo_level !== 4'd1) begin errors++; $display("FAIL random_level[%0d]: got %0d expected 1", n, fifo_level); end
            pop_one();
        end
    endtask

    task automatic test_overrun();
        logic [10:0] exp;
        for (int i = 1; i <= 9; i++) begin
            send_frame(8'(i), 2'b00, 1'b0, 1'b1, BIT);
            if (i <= 8) exp_q.push_back(model_word(8'(i), 2'b00, 1'b0, 1'b1));
        end
        checks++; if (fifo_level !== 4'd8) begin errors++; $display("FAIL ovr_level: got %0d expected 8", fifo_level); end
        checks++; if (rx_overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b expected 1", rx_overrun); end
        rx_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp = exp_q.pop_front();
            checks++; if (head !== exp) begin errors++; $display("FAIL ovr_pop[%0d]: got %h expected %h", i, head, exp); end
            pop_one();
        end
        checks++; if (rx_valid !== 1'b0 || fifo_level !== 4'd0) begin
            errors++; $display("FAIL ovr_drained: got valid=%b level=%0d expected valid=0 level=0", rx_valid, fifo_level);
        end
        checks++; if (rx_overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b expected 1", rx_overrun); end
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        @(negedge clk);
        checks++; if (rx_overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b expected 0", rx_overrun); end
        rx_en = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // The 445-clock frame is left in the FIFO so the reset test starts from non-zero outputs.
    task automatic test_baud_tolerance();
        logic [10:0] exp;
        exp = model_word(8'h5A, 2'b00, 1'b0, 1'b1);
        send_frame(8'h5A, 2'b00, 1'b0, 1'b1, 419);
        checks++; if (head !== exp) begin errors++; $display("FAIL baud_fast: got %h expected %h", head, exp); end
        pop_one();
        send_frame(8'h5A, 2'b00, 1'b0, 1'b1, 445);
        checks++; if (head !== exp) begin errors++; $display("FAIL baud_slow: got %h expected %h", head, exp); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0]  d;
        logic [10:0] exp;
        d = 8'h5A;
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre_valid: got %b expected 1", rx_valid); end
        rxd = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rxd = d[i];
            repeat (BIT) @(negedge clk);
        end
        rxd = d[3];
        repeat (BIT / 2) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", rx_valid); end
        checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL rstmid_level: got %0d expected 0", fifo_level); end
        checks++; if (head !== 11'h000) begin errors++; $display("FAIL rstmid_head: got %h expected 000", head); end
        rxd = 1'b1;
        repeat (BIT) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        send_frame(d, 2'b00, 1'b0, 1'b1, BIT);
        exp = model_word(d, 2'b00, 1'b0, 1'b1);
        checks++; if (head !== exp) begin errors++; $display("FAIL rstmid_next: got %h expected %h", head, exp); end
        checks++; if (fifo_level !== 4'd1) begin errors++; $display("FAIL rstmid_next_level: got %0d expected 1", fifo_level); end
        pop_one();
    endtask

    initial begin
        reset       = 1'b0;
        baud_select = 3'b111;
        parity_mode = 2'b00;
        rx_en       = 1'b1;
        rxd         = 1'b1;
        rx_pop      = 1'b0;
        ovr_clr     = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_parity_error();
        test_framing_break();
        test_false_start();
        test_abort();
        test_random();
        test_overrun();
        test_baud_tolerance();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
